// File: rtl/mesh_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mesh_sweep_ctrl
// Purpose  : Sequencer for a ROWS x COLS toroidal mesh of two-bit nodes.
//            Holds the cell states, which a host loads row by row. Drives
//            the states onto the mesh and samples the mesh's per-node flags.
//            Flagged cells are advanced (state+1 mod 4) in repeated sweeps
//            until the mesh reports no flags or MAX_ITER sweeps have been
//            applied. The final states are read back through a registered
//            row readout port.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional build macro:
//   MESH_CTRL_PARITY_EN - checkerboard update. On a sweep, only cells with
//                         ((row+col)&1)==phase may advance. phase starts at
//                         0 and toggles after every applied sweep.
// ----------------------------------------------------------------------------
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   load_valid  in   host row write strobe (honoured in IDLE only)
//   load_ready  out  high while IDLE
//   load_data   in   row states, bits [2c+1:2c] = column c
//   start       in   begin sweeping (sampled in IDLE only)
//   abort       in   abandon the run from SETTLE/EVAL, back to IDLE
//   mesh_inp    out  state vector to mesh, bits [2j+1:2j] = node j
//   mesh_out    in   per-node flag from mesh
//   busy        out  high in SETTLE/EVAL
//   done        out  one-cycle pulse at the end of a run
//   converged   out  last run ended with no flags raised
//   iter_count  out  sweeps applied in the last/current run
//   rd_row      in   readout row select
//   rd_data     out  states of row rd_row, one cycle latency
// ============================================================================
module mesh_sweep_ctrl #(
    parameter int COLS     = 26,
    parameter int ROWS     = 18,
    parameter int MESH_LAT = 1,
    parameter int MAX_ITER = 1023
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic [2*COLS-1:0]            load_data,
    input  logic                         start,
    input  logic                         abort,
    output logic [2*ROWS*COLS-1:0]       mesh_inp,
    input  logic [ROWS*COLS-1:0]         mesh_out,
    output logic                         busy,
    output logic                         done,
    output logic                         converged,
    output logic [15:0]                  iter_count,
    input  logic [$clog2(ROWS)-1:0]      rd_row,
    output logic [2*COLS-1:0]            rd_data
);

    localparam int                    c_row_w    = $clog2(ROWS);
    localparam int                    c_cnt_w    = (MESH_LAT > 1) ? $clog2(MESH_LAT) : 1;
    localparam logic [c_cnt_w-1:0]    c_cnt_last = c_cnt_w'(MESH_LAT - 1);
    localparam logic [c_row_w-1:0]    c_row_last = c_row_w'(ROWS - 1);
    localparam logic [15:0]           c_max_iter = 16'(MAX_ITER);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_EVAL   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t                r_state;
    logic [2*COLS-1:0]     r_cells [ROWS];
    logic [c_row_w-1:0]    r_wr_ptr;
    logic [c_cnt_w-1:0]    r_cnt;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_conv;
    logic [15:0]           r_iter;
    logic [2*COLS-1:0]     r_rd;
    logic [ROWS*COLS-1:0]  w_upd;

    // Mesh input is the state array itself, so it only moves when a row
    // is written or a sweep is applied.
    generate
        for (genvar gr = 0; gr < ROWS; gr++) begin : g_mesh_pack
            assign mesh_inp[gr*2*COLS +: 2*COLS] = r_cells[gr];
        end
    endgenerate

`ifdef MESH_CTRL_PARITY_EN
    logic r_phase;

    // Each node's checkerboard colour is fixed at elaboration; a flagged
    // node only advances when its colour matches the current phase.
    generate
        for (genvar gr = 0; gr < ROWS; gr++) begin : g_elig_row
            for (genvar gc = 0; gc < COLS; gc++) begin : g_elig_col
                localparam logic c_par = 1'((gr + gc) % 2);
                assign w_upd[gr*COLS+gc] = mesh_out[gr*COLS+gc] & (c_par == r_phase);
            end
        end
    endgenerate
`else
    assign w_upd = mesh_out;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_conv   <= 1'b0;
            r_iter   <= '0;
            r_rd     <= '0;
            for (int r = 0; r < ROWS; r++) begin
                r_cells[r] <= '0;
            end
`ifdef MESH_CTRL_PARITY_EN
            r_phase  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            // Readout samples the array before this edge's write/update.
            r_rd   <= (rd_row <= c_row_last) ? r_cells[rd_row] : '0;

            case (r_state)
                ST_IDLE: begin
                    if (load_valid) begin
                        r_cells[r_wr_ptr] <= load_data;
                        r_wr_ptr <= (r_wr_ptr == c_row_last) ? '0 : r_wr_ptr + c_row_w'(1);
                    end
                    // start wins over the pointer increment of a same-cycle
                    // write; the write data itself still lands.
                    if (start) begin
                        r_wr_ptr <= '0;
                        r_iter   <= '0;
                        r_conv   <= 1'b0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_SETTLE;
`ifdef MESH_CTRL_PARITY_EN
                        r_phase  <= 1'b0;
`endif
                    end
                end

                ST_SETTLE: begin
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state <= ST_EVAL;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end

                ST_EVAL: begin
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (mesh_out == '0) begin
                        r_conv  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (r_iter == c_max_iter) begin
                        r_conv  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        for (int r = 0; r < ROWS; r++) begin
                            for (int c = 0; c < COLS; c++) begin
                                if (w_upd[r*COLS+c]) begin
                                    r_cells[r][2*c +: 2] <= r_cells[r][2*c +: 2] + 2'd1;
                                end
                            end
                        end
                        r_iter  <= r_iter + 16'd1;
                        r_cnt   <= '0;
                        r_state <= ST_SETTLE;
`ifdef MESH_CTRL_PARITY_EN
                        r_phase <= ~r_phase;
`endif
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign load_ready = (r_state == ST_IDLE);
    assign busy       = r_busy;
    assign done       = r_done;
    assign converged  = r_conv;
    assign iter_count = r_iter;
    assign rd_data    = r_rd;

endmodule
`default_nettype wire
